// File: rtl/sys_ctrl_seq.sv
// rtl/sys_ctrl_seq.sv - per-domain clock/reset sequencer and boot register block
//
// Register window (4 KiB, word stride, addr[1:0] ignored), d = domain index:
//   0x000+4d CLK_RST     wr [0]=clk_req [1]=rst_n_req; rd [0]=clk_en [1]=rst_n [2]=busy [5:4]=req
//   0x040+4d BOOT_ADDR   0x080+4d BOOT_HARTID   0x0C0+4d PLL_CFG
// Ports:
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i      single-outstanding register request
//   gnt_o                          request accepted (blocked while a response is pending)
//   rvalid_o/rdata_o/err_o         response, one cycle after grant
//   dom_clk_en_o/dom_rst_no        per-domain clock enable and active-low reset
//   dom_busy_o                     per-domain sequencer counting (SETTLE or DRAIN)
//   boot_addr_o/hartid_o/pll_cfg_o per-domain configuration words, flattened
module sys_ctrl_seq #(
    parameter int                NUM_DOM    = 5,
    parameter int                DW         = 32,
    parameter int                SETTLE_W   = 8,
    parameter int                CLK_SETTLE = 8,
    parameter int                RST_HOLD   = 4,
    parameter logic [NUM_DOM-1:0] AUTO_ON   = 'b1,
    parameter logic [DW-1:0]     BOOT_RST   = DW'(32'h0900_0000)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [11:0]           addr_i,
    input  logic [DW-1:0]         wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  err_o,
    output logic [NUM_DOM-1:0]    dom_clk_en_o,
    output logic [NUM_DOM-1:0]    dom_rst_no,
    output logic [NUM_DOM-1:0]    dom_busy_o,
    output logic [NUM_DOM*DW-1:0] boot_addr_o,
    output logic [NUM_DOM*DW-1:0] hartid_o,
    output logic [NUM_DOM*DW-1:0] pll_cfg_o
);

    localparam logic [2:0] ST_OFF    = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(CLK_SETTLE - 1);
    localparam logic [SETTLE_W-1:0] HOLD_LOAD   = SETTLE_W'(RST_HOLD - 1);
    localparam logic [SETTLE_W-1:0] CNT_ONE     = SETTLE_W'(1);
    localparam logic [4:0]          NUM_DOM_W   = 5'(NUM_DOM);

    // request bits per domain: [0]=clk_req, [1]=rst_n_req
    logic [1:0]          req_q   [NUM_DOM];
    logic [DW-1:0]       boot_q  [NUM_DOM];
    logic [DW-1:0]       hart_q  [NUM_DOM];
    logic [DW-1:0]       pll_q   [NUM_DOM];
    logic [2:0]          st_q    [NUM_DOM];
    logic [2:0]          st_d    [NUM_DOM];
    logic [SETTLE_W-1:0] cnt_q   [NUM_DOM];
    logic [SETTLE_W-1:0] cnt_d   [NUM_DOM];
    logic [NUM_DOM-1:0]  clk_en_q;
    logic [NUM_DOM-1:0]  rst_n_q;
    logic [NUM_DOM-1:0]  busy_q;

    logic                rvalid_q;
    logic                err_q;
    logic [DW-1:0]       rdata_q;

    logic [3:0]          a_dom;
    logic [1:0]          a_grp;
    logic                hit;
    logic                gnt;
    logic                wr;
    logic [DW-1:0]       rd_word;
    logic                unused_addr;

    // ---------------- bus decode ----------------
    assign a_dom       = addr_i[5:2];
    assign a_grp       = addr_i[7:6];
    assign hit         = (addr_i[11:8] == 4'd0) && ({1'b0, a_dom} < NUM_DOM_W);
    assign gnt         = req_i & ~rvalid_q;
    assign wr          = gnt & we_i & hit;
    assign unused_addr = ^addr_i[1:0];

    // Read data reflects the pins as they are at the grant edge.
    always_comb begin
        rd_word = '0;
        for (int d = 0; d < NUM_DOM; d++) begin
            if (a_dom == 4'(d)) begin
                case (a_grp)
                    2'd0: rd_word = DW'({req_q[d], 1'b0, busy_q[d], rst_n_q[d], clk_en_q[d]});
                    2'd1: rd_word = boot_q[d];
                    2'd2: rd_word = hart_q[d];
                    2'd3: rd_word = pll_q[d];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt & ~hit;
            rdata_q  <= (gnt && hit && !we_i) ? rd_word : '0;
        end
    end

    // ---------------- configuration registers ----------------
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int d = 0; d < NUM_DOM; d++) begin
                req_q[d]  <= AUTO_ON[d] ? 2'b11 : 2'b00;
                boot_q[d] <= BOOT_RST;
                hart_q[d] <= DW'(d);
                pll_q[d]  <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_DOM; d++) begin
                if (wr && (a_dom == 4'(d))) begin
                    case (a_grp)
                        2'd0: req_q[d]  <= wdata_i[1:0];
                        2'd1: boot_q[d] <= wdata_i;
                        2'd2: hart_q[d] <= wdata_i;
                        2'd3: pll_q[d]  <= wdata_i;
                    endcase
                end
            end
        end
    end

    // ---------------- sequencers ----------------
    // req_q is read before this edge's write lands, so a write coinciding with
    // a transition is only seen on the following cycle.
    always_comb begin
        for (int d = 0; d < NUM_DOM; d++) begin
            st_d[d]  = st_q[d];
            cnt_d[d] = cnt_q[d];
            case (st_q[d])
                ST_OFF: begin
                    if (req_q[d][0]) begin
                        st_d[d]  = ST_SETTLE;
                        cnt_d[d] = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q[d] == '0) st_d[d] = ST_HELD;
                    else                cnt_d[d] = cnt_q[d] - CNT_ONE;
                end
                ST_HELD: begin
                    if (req_q[d] == 2'b11)  st_d[d] = ST_RUN;
                    else if (!req_q[d][0])  st_d[d] = ST_OFF;
                end
                ST_RUN: begin
                    if (req_q[d] != 2'b11) begin
                        st_d[d]  = ST_DRAIN;
                        cnt_d[d] = HOLD_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // always returns through HELD so the clock never gates
                    // in the same step that reset was still being drained
                    if (cnt_q[d] == '0) st_d[d] = ST_HELD;
                    else                cnt_d[d] = cnt_q[d] - CNT_ONE;
                end
                default: st_d[d] = ST_OFF;
            endcase
        end
    end

    // Pin flops are loaded from the next state so they switch on the same
    // edge as the state itself (reset falls with the RUN->DRAIN edge).
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int d = 0; d < NUM_DOM; d++) begin
                st_q[d]  <= ST_OFF;
                cnt_q[d] <= '0;
            end
            clk_en_q <= '0;
            rst_n_q  <= '0;
            busy_q   <= '0;
        end else begin
            for (int d = 0; d < NUM_DOM; d++) begin
                st_q[d]     <= st_d[d];
                cnt_q[d]    <= cnt_d[d];
                clk_en_q[d] <= (st_d[d] != ST_OFF);
                rst_n_q[d]  <= (st_d[d] == ST_RUN);
                busy_q[d]   <= (st_d[d] == ST_SETTLE) || (st_d[d] == ST_DRAIN);
            end
        end
    end

    // ---------------- outputs ----------------
    assign gnt_o        = gnt;
    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign dom_clk_en_o = clk_en_q;
    assign dom_rst_no   = rst_n_q;
    assign dom_busy_o   = busy_q;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_flat
        assign boot_addr_o[g*DW +: DW] = boot_q[g];
        assign hartid_o[g*DW +: DW]    = hart_q[g];
        assign pll_cfg_o[g*DW +: DW]   = pll_q[g];
    end

endmodule
